// File: rtl/proc_elem_pkg.sv
// Shared types and arithmetic helpers for the convolution processing-element family.
package proc_elem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } pe_state_t;

  // Round half-up, right shift by 'shift', then clamp to an unsigned 'width'-bit range.
  function automatic logic [63:0] sat_round(input logic [63:0] acc,
                                            input int unsigned shift,
                                            input int unsigned width);
    logic [63:0] r;
    logic [63:0] lim;
    if (shift == 0) r = acc;
    else            r = (acc + (64'd1 << (shift - 1))) >> shift;
    lim = (64'd1 << width) - 64'd1;
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/proc_elem_seq_lane_mac.sv
// Combinational sum of LANES unsigned pixel*weight products for one beat slice.
module lane_mac #(
  parameter int LANES   = 3,
  parameter int PX_SIZE = 8
) (
  input  logic [LANES*PX_SIZE-1:0]          px,
  input  logic [LANES*PX_SIZE-1:0]          wt,
  output logic [2*PX_SIZE+$clog2(LANES):0]  sum
);

  localparam int SUM_W = 2*PX_SIZE + $clog2(LANES) + 1;

  always_comb begin
    logic [2*PX_SIZE-1:0] a;
    logic [2*PX_SIZE-1:0] b;
    a   = '0;
    b   = '0;
    sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a   = (2*PX_SIZE)'(px[l*PX_SIZE +: PX_SIZE]);
      b   = (2*PX_SIZE)'(wt[l*PX_SIZE +: PX_SIZE]);
      sum = sum + SUM_W'(a * b);
    end
  end

endmodule

// File: rtl/proc_elem_seq.sv
// Sequential convolution PE: time-multiplexes LANES multipliers over a K*K*C window,
// then rounds/shifts/saturates into one output pixel behind valid/ready handshakes.
module proc_elem_seq
  import proc_elem_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  parameter int INPUT_CHANNELS = 1,
  parameter int LANES          = 3,
  parameter int OUT_SHIFT      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_in,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] kernel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PX_SIZE-1:0]   img_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int NUM_INPUTS = KERNEL_SIZE * KERNEL_SIZE * INPUT_CHANNELS;
  localparam int BEATS      = NUM_INPUTS / LANES;
  localparam int ACC_W      = 2*PX_SIZE + $clog2(NUM_INPUTS) + 1;
  localparam int SUM_W      = 2*PX_SIZE + $clog2(LANES) + 1;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W    = LANES * PX_SIZE;
  localparam int VEC_W      = NUM_INPUTS * PX_SIZE;

  if (LANES < 1 || (NUM_INPUTS % LANES) != 0) begin : g_lanes_chk
    $error("proc_elem_seq: LANES must divide KERNEL_SIZE^2*INPUT_CHANNELS");
  end

  pe_state_t          state;
  logic [BEAT_W-1:0]  beat;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [VEC_W-1:0]   img_r;
  logic [VEC_W-1:0]   ker_r;
  logic [SLICE_W-1:0] img_slice;
  logic [SLICE_W-1:0] ker_slice;
  logic [SUM_W-1:0]   lane_sum;
  logic               accept;
  logic               last_beat;

  always_comb begin
    in_ready = (state == IDLE) || ((state == OUT) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Packed window flattens so that element [x][y][c] sits at slot ((x*K)+y)*C+c.
  always_comb begin
    int unsigned base;
    base      = 32'(beat) * SLICE_W;
    img_slice = img_r[base +: SLICE_W];
    ker_slice = ker_r[base +: SLICE_W];
  end

  lane_mac #(
    .LANES   (LANES),
    .PX_SIZE (PX_SIZE)
  ) u_lane_mac (
    .px  (img_slice),
    .wt  (ker_slice),
    .sum (lane_sum)
  );

  always_comb begin
    acc_next  = acc + ACC_W'(lane_sum);
    last_beat = (beat == BEAT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      img_out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (last_beat) begin
            beat      <= '0;
            img_out   <= PX_SIZE'(sat_round(64'(acc_next), OUT_SHIFT, PX_SIZE));
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? MAC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Operand capture shared by IDLE and OUT accepts; never fires while in MAC.
      if (accept) begin
        img_r <= img_in;
        ker_r <= kernel;
        acc   <= '0;
        beat  <= '0;
      end
    end
  end

endmodule

// File: doc/proc_elem_seq.md
# proc_elem_seq

Sequential, parametrised convolution processing element: computes one output pixel from a KERNEL_SIZE × KERNEL_SIZE × INPUT_CHANNELS neighbourhood and kernel. It time-multiplexes LANES multipliers over the products and keeps a full-width accumulator. The result is rounded, shifted and saturated. It sits between the line-buffer/window generator and the output pixel stream, with valid/ready handshakes on both sides, so arrays of PEs can trade area for throughput.

## Interface
- KERNEL_SIZE, 3, kernel width/height (square)
- PX_SIZE, 8, bits per unsigned pixel and per unsigned kernel weight
- INPUT_CHANNELS, 1, channels per pixel
- LANES, 3, multipliers used per cycle; must divide NUM_INPUTS (elaboration error otherwise)
- OUT_SHIFT, 8, right shift applied to accumulator before saturation (0 allowed)
- localparam NUM_INPUTS = KERNEL_SIZE²·INPUT_CHANNELS; BEATS = NUM_INPUTS/LANES; ACC_W = 2·PX_SIZE + $clog2(NUM_INPUTS)+1
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- img_in  in  [K][K][C][PX_SIZE]  neighbourhood pixels
- kernel  in  [K][K][C][PX_SIZE]  weights
- in_valid  in  1  img_in/kernel valid
- in_ready  out  1  PE can accept
- img_out  out  PX_SIZE  result pixel, registered
- out_valid  out  1  img_out valid
- out_ready  in  1  downstream accepts

## Operation
- States: IDLE, MAC, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, register img_in and kernel, clear acc and beat counter, go to MAC.
- Flattened index i = ((x·K)+y)·C + c. Beat b covers i = b·LANES … b·LANES+LANES−1.
- MAC: each cycle add the sum of that beat's LANES products (each 2·PX_SIZE wide) to acc. Increment beat. On the edge processing beat BEATS−1, go to OUT.
- The same edge computes img_out: r = (acc_final + 2^(OUT_SHIFT−1)) >> OUT_SHIFT; with OUT_SHIFT=0, r = acc_final. img_out = min(r, 2^PX_SIZE−1).
- OUT: out_valid=1; img_out held stable until out_ready.
  - out_ready && in_valid: accept the new input on the same edge and go to MAC.
  - out_ready only: go to IDLE.
- in_ready = (state==IDLE) || (state==OUT && out_ready). This is a combinational path from out_ready and is permitted.
- Inputs are sampled only on the accept edge; changes to img_in/kernel afterwards have no effect.
- No overflow inside acc is possible, by the ACC_W choice.

## Timing
- Reset values: in_ready=1 after reset (state IDLE), out_valid=0, img_out=0, acc=0, beat=0.
- Reset asserted in any state: the next edge returns to IDLE and any in-flight result is discarded. No out_valid pulse is emitted for it.
- Latency: accept edge at T. MAC edges are T+1…T+BEATS. out_valid is high from T+BEATS (default: 3 edges after accept).
- Throughput with out_ready held 1: one result every BEATS+1 cycles.
- out_valid, once high, stays high with img_out constant until the out_ready edge (no retraction).
- BEATS=1 (LANES=NUM_INPUTS): MAC lasts exactly one cycle; behaviour is otherwise identical.

## Structure
- Package proc_elem_pkg:
  - state enum pe_state_t {IDLE, MAC, OUT}
  - function sat_round(acc, shift, width) for the shift/round/saturate rule, shared with future PE variants
- Sub-module lane_mac: combinational sum of LANES products from one beat slice, output width 2·PX_SIZE+$clog2(LANES)+1. The top level holds the FSM, beat counter, operand registers, accumulator and output register.

## Test plan
- Defaults; all img=16, all kernel=16 -> acc=2304, img_out=9, out_valid at 3 edges after accept.
- Defaults; all img=255, all kernel=255 -> acc=585225, saturates, img_out=255.
- Defaults; only img[0][0][0]=1 with kernel[0][0][0]=128 -> img_out=1. Same with kernel=127 -> img_out=0 (rounding boundary).
- Back-to-back: in_valid held high, out_ready=1, two vectors (16/16 then 255/255) -> results 9 then 255, four cycles apart, second accepted on the first's out_ready edge.
- Backpressure: out_ready=0 for 10 cycles while in OUT -> img_out stable, out_valid stays 1, in_ready=0, new inputs not accepted. Release -> one transfer.
- rst asserted mid-MAC (beat 1) -> next cycle in_ready=1, out_valid=0, img_out=0. A subsequent 16/16 vector yields 9 with no stale contribution. Repeat with LANES=9, and with LANES=1 (BEATS=9), checking latency.
